// File: rtl/reg8_pkg.sv
// Shared widths and encodings for the 8x8 register-bank execute sequencer.
package reg8_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SLL = 3'd5,
    OP_SRL = 3'd6,
    OP_LI  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_e;

endpackage

// File: rtl/reg8_alu.sv
// Combinational ALU: arithmetic, logic, shifts and load-immediate with zero/carry flags.
module reg8_alu #(
  parameter int DATA_W = reg8_pkg::DATA_W
) (
  input  reg8_pkg::op_e      op,
  input  logic [DATA_W-1:0]  a,
  input  logic [DATA_W-1:0]  b,
  input  logic [DATA_W-1:0]  imm,
  output logic [DATA_W-1:0]  result,
  output logic               z,
  output logic               c
);
  import reg8_pkg::*;

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;
  logic [2:0]      shamt;

  // Extra top bit carries out of ADD and borrows out of SUB (set when a < b unsigned).
  assign sum   = {1'b0, a} + {1'b0, b};
  assign diff  = {1'b0, a} - {1'b0, b};
  assign shamt = b[2:0];

  always_comb begin
    result = '0;
    c      = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum[DATA_W-1:0];
        c      = sum[DATA_W];
      end
      OP_SUB: begin
        result = diff[DATA_W-1:0];
        c      = diff[DATA_W];
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_SLL:  result = a << shamt;
      OP_SRL:  result = a >> shamt;
      OP_LI:   result = imm;
      default: result = '0;
    endcase
  end

  assign z = (result == '0);

endmodule

// File: rtl/reg8_op_sequencer.sv
// Four-state execute/write-back sequencer: capture instruction, read bank, execute, commit.
module reg8_op_sequencer #(
  parameter int DATA_W = reg8_pkg::DATA_W,
  parameter int ADDR_W = reg8_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        instr_op,
  input  logic [ADDR_W-1:0] instr_rd,
  input  logic [ADDR_W-1:0] instr_rs1,
  input  logic [ADDR_W-1:0] instr_rs2,
  input  logic [DATA_W-1:0] instr_imm,
  output logic [ADDR_W-1:0] rf_raddr_1,
  output logic [ADDR_W-1:0] rf_raddr_2,
  input  logic [DATA_W-1:0] rf_rdata_1,
  input  logic [DATA_W-1:0] rf_rdata_2,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              done,
  output logic              flag_z,
  output logic              flag_c
);
  import reg8_pkg::*;

  state_e              state_q,  state_d;
  op_e                 op_q,     op_d;
  logic [ADDR_W-1:0]   rd_q,     rd_d;
  logic [ADDR_W-1:0]   rs1_q,    rs1_d;
  logic [ADDR_W-1:0]   rs2_q,    rs2_d;
  logic [DATA_W-1:0]   imm_q,    imm_d;
  logic [DATA_W-1:0]   a_q,      a_d;
  logic [DATA_W-1:0]   b_q,      b_d;
  logic [DATA_W-1:0]   res_q,    res_d;
  logic                res_z_q,  res_z_d;
  logic                res_c_q,  res_c_d;
  logic                flag_z_q, flag_z_d;
  logic                flag_c_q, flag_c_d;

  logic [DATA_W-1:0]   alu_res;
  logic                alu_z;
  logic                alu_c;

  reg8_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .imm    (imm_q),
    .result (alu_res),
    .z      (alu_z),
    .c      (alu_c)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rd_d     = rd_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    imm_d    = imm_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    res_z_d  = res_z_q;
    res_c_d  = res_c_q;
    flag_z_d = flag_z_q;
    flag_c_d = flag_c_q;
    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          op_d    = op_e'(instr_op);
          rd_d    = instr_rd;
          rs1_d   = instr_rs1;
          rs2_d   = instr_rs2;
          imm_d   = instr_imm;
          state_d = READ;
        end
      end
      READ: begin
        a_d     = rf_rdata_1;
        b_d     = rf_rdata_2;
        state_d = EXEC;
      end
      EXEC: begin
        res_d   = alu_res;
        res_z_d = alu_z;
        res_c_d = alu_c;
        state_d = WB;
      end
      WB: begin
        // Flags follow the committed result, so they become visible once back in IDLE.
        flag_z_d = res_z_q;
        flag_c_d = res_c_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= OP_ADD;
      rd_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      imm_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      res_z_q  <= 1'b0;
      res_c_q  <= 1'b0;
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      imm_q    <= imm_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      res_z_q  <= res_z_d;
      res_c_q  <= res_c_d;
      flag_z_q <= flag_z_d;
      flag_c_q <= flag_c_d;
    end
  end

  // Bank-facing outputs are gated to zero outside their own state.
  always_comb begin
    instr_ready = (state_q == IDLE);
    done        = (state_q == WB);
    rf_raddr_1  = (state_q == READ) ? rs1_q : '0;
    rf_raddr_2  = (state_q == READ) ? rs2_q : '0;
    rf_we       = (state_q == WB) && (rd_q != '0);
    rf_waddr    = (state_q == WB) ? rd_q  : '0;
    rf_wdata    = (state_q == WB) ? res_q : '0;
    flag_z      = flag_z_q;
    flag_c      = flag_c_q;
  end

endmodule

// File: tb/tb_reg8_op_sequencer.sv
// Directed bench: sequencer plus a behavioural 8x8 register bank, hand-computed expectations.
module tb_reg8_op_sequencer;
  import reg8_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       bank_rst_n = 1'b0;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic [2:0] instr_op = '0;
  logic [2:0] instr_rd = '0;
  logic [2:0] instr_rs1 = '0;
  logic [2:0] instr_rs2 = '0;
  logic [7:0] instr_imm = '0;
  logic [2:0] rf_raddr_1, rf_raddr_2, rf_waddr;
  logic [7:0] rf_rdata_1, rf_rdata_2, rf_wdata;
  logic       rf_we, done, flag_z, flag_c;

  logic [7:0] bank [8];
  int         wr_cnt = 0;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  int         last_lat = 0;

  always #5 clk = ~clk;

  reg8_op_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs1(instr_rs1),
    .instr_rs2(instr_rs2), .instr_imm(instr_imm),
    .rf_raddr_1(rf_raddr_1), .rf_raddr_2(rf_raddr_2),
    .rf_rdata_1(rf_rdata_1), .rf_rdata_2(rf_rdata_2),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .done(done), .flag_z(flag_z), .flag_c(flag_c)
  );

  // Register bank: X0 reads as zero, writes land on posedge; preload while held in reset.
  assign rf_rdata_1 = (rf_raddr_1 == 3'd0) ? 8'h00 : bank[rf_raddr_1];
  assign rf_rdata_2 = (rf_raddr_2 == 3'd0) ? 8'h00 : bank[rf_raddr_2];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!bank_rst_n) begin
      for (int i = 0; i < 8; i++) bank[i] <= 8'h00;
      bank[7] <= 8'hA5;
    end else if (rf_we) begin
      bank[rf_waddr] <= rf_wdata;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, input logic [7:0] imm);
    instr_op = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2; instr_imm = imm;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", instr_ready, 1);
  endtask

  // Issue one instruction, scramble inputs after accept, wait for done, land 1ns after write edge.
  task automatic run_op(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                        input logic [2:0] rs2, input logic [7:0] imm);
    int n;
    @(negedge clk);
    drive(op, rd, rs1, rs2, imm);
    instr_valid = 1'b1;
    wait_ready();
    @(posedge clk); #1;
    instr_valid = 1'b0;
    drive(3'd1, 3'd7, 3'd5, 3'd6, 8'hEE);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 10);
    last_lat = n;
    chk("done_seen", done, 1);
    @(posedge clk); #1;
    chk("done_pulse", done, 0);
  endtask

  initial begin
    int w0;
    int acc [3];

    #1;
    chk("rst_ready", instr_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_we", rf_we, 0);
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_raddr", {rf_raddr_1, rf_raddr_2}, 0);
    chk("rst_flags", {flag_z, flag_c}, 0);
    repeat (2) @(negedge clk);
    bank_rst_n = 1'b1;
    rst_n = 1'b1;

    // Basic ADD with latency check
    run_op(OP_LI, 3'd1, 3'd0, 3'd0, 8'h7F);
    run_op(OP_LI, 3'd2, 3'd0, 3'd0, 8'h01);
    run_op(OP_ADD, 3'd3, 3'd1, 3'd2, 8'h00);
    chk("add_x3", bank[3], 8'h80);
    chk("add_zc", {flag_z, flag_c}, 2'b00);
    chk("add_latency", last_lat, 3);

    // Carry and borrow
    run_op(OP_LI, 3'd1, 3'd0, 3'd0, 8'hFF);
    run_op(OP_ADD, 3'd4, 3'd1, 3'd2, 8'h00);
    chk("addc_x4", bank[4], 8'h00);
    chk("addc_zc", {flag_z, flag_c}, 2'b11);
    run_op(OP_SUB, 3'd5, 3'd2, 3'd1, 8'h00);
    chk("sub_x5", bank[5], 8'h02);
    chk("sub_zc", {flag_z, flag_c}, 2'b01);

    // Shifts and logic
    run_op(OP_LI, 3'd1, 3'd0, 3'd0, 8'h81);
    chk("li_c_clear", flag_c, 0);
    run_op(OP_LI, 3'd2, 3'd0, 3'd0, 8'h03);
    run_op(OP_SLL, 3'd6, 3'd1, 3'd2, 8'h00);
    chk("sll_x6", bank[6], 8'h08);
    run_op(OP_SRL, 3'd6, 3'd1, 3'd2, 8'h00);
    chk("srl_x6", bank[6], 8'h10);
    run_op(OP_SLL, 3'd6, 3'd1, 3'd0, 8'h00);
    chk("sll0_x6", bank[6], 8'h81);
    run_op(OP_AND, 3'd3, 3'd1, 3'd2, 8'h00);
    chk("and_x3", bank[3], 8'h01);
    run_op(OP_OR, 3'd3, 3'd1, 3'd2, 8'h00);
    chk("or_x3", bank[3], 8'h83);
    run_op(OP_XOR, 3'd3, 3'd1, 3'd1, 8'h00);
    chk("xor_x3", bank[3], 8'h00);
    chk("xor_zc", {flag_z, flag_c}, 2'b10);

    // rd == 0: sequence runs, no write
    w0 = wr_cnt;
    run_op(OP_LI, 3'd0, 3'd0, 3'd0, 8'h55);
    chk("rd0_writes", wr_cnt - w0, 0);
    chk("rd0_bank", bank[0], 8'h00);
    chk("rd0_zc", {flag_z, flag_c}, 2'b00);

    // Back-to-back with valid held high
    w0 = wr_cnt;
    @(negedge clk);
    instr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 0) drive(OP_LI, 3'd1, 3'd0, 3'd0, 8'h11);
      else if (i == 1) drive(OP_LI, 3'd2, 3'd0, 3'd0, 8'h22);
      else drive(OP_ADD, 3'd3, 3'd1, 3'd2, 8'h00);
      wait_ready();
      @(posedge clk); #1;
      acc[i] = cyc;
      if (i == 2) instr_valid = 1'b0;
      @(negedge clk);
    end
    chk("b2b_gap1", acc[1] - acc[0], 4);
    chk("b2b_gap2", acc[2] - acc[1], 4);
    repeat (4) @(negedge clk);
    chk("b2b_writes", wr_cnt - w0, 3);
    chk("b2b_x3", bank[3], 8'h33);

    // Reset during EXEC aborts the write
    run_op(OP_LI, 3'd1, 3'd0, 3'd0, 8'hFF);
    run_op(OP_ADD, 3'd4, 3'd1, 3'd1, 8'h00);
    chk("pre_rst_x4", bank[4], 8'hFE);
    chk("pre_rst_c", flag_c, 1);
    @(negedge clk);
    drive(OP_ADD, 3'd7, 3'd1, 3'd2, 8'h00);
    instr_valid = 1'b1;
    wait_ready();
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    w0 = wr_cnt;
    rst_n = 1'b0;
    #1;
    chk("abort_ready", instr_ready, 1);
    chk("abort_outs", {rf_we, done, flag_z, flag_c}, 4'b0000);
    chk("abort_wbus", {rf_waddr, rf_wdata}, 0);
    repeat (3) @(negedge clk);
    chk("abort_writes", wr_cnt - w0, 0);
    chk("abort_x7", bank[7], 8'hA5);
    rst_n = 1'b1;
    run_op(OP_LI, 3'd7, 3'd0, 3'd0, 8'h3C);
    chk("post_rst_x7", bank[7], 8'h3C);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
